// File: rtl/wgt_loader.sv
`default_nettype none
// ============================================================================
// wgt_loader : fetches one KSIZE x KSIZE signed kernel from weight SRAM and
//              streams it row by row into the weight shift buffer.
// Option     : WGT_RDATA_REG_EN adds a pipeline register on SRAM read data.
// Revision   : 1.0
// ============================================================================
module wgt_loader #(
   parameter int KSIZE  = 5,
   parameter int ADDR_W = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   output logic                wgt_rd_en,
   output logic [ADDR_W-1:0]   wgt_addr,
   input  logic signed [7:0]   wgt_rdata,
   output logic signed [7:0]   wgt_input,
   output logic                wgt_read,
   output logic                row_valid,
   input  logic                row_ack,
   output logic                busy,
   output logic                done
);

   localparam int c_COL_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
   localparam int c_ROW_W = $clog2(KSIZE + 1);
`ifdef WGT_RDATA_REG_EN
   localparam int c_LAT = 2;
`else
   localparam int c_LAT = 1;
`endif
   localparam logic [c_COL_W-1:0] c_LAST_COL  = c_COL_W'(KSIZE - 1);
   localparam logic [c_ROW_W-1:0] c_LAST_ROW  = c_ROW_W'(KSIZE - 1);
   localparam logic               c_DRN_LAST  = 1'(c_LAT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      DRAIN = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t              r_state;
   logic [c_COL_W-1:0]  r_col;
   logic [c_ROW_W-1:0]  r_row;
   logic                r_drain;
   logic                r_rd_en;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_row_valid;
   logic                r_busy;
   logic                r_done;
   logic                r_rd_d1;

   // Addresses run contiguously across rows, so a single incrementer
   // replaces base + row*KSIZE + col.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_col       <= '0;
         r_row       <= '0;
         r_drain     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_addr      <= '0;
         r_row_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_addr  <= base_addr;
                  r_col   <= '0;
                  r_row   <= '0;
                  r_rd_en <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= FETCH;
               end
            end
            FETCH: begin
               if (r_col == c_LAST_COL) begin
                  r_rd_en <= 1'b0;
                  r_drain <= 1'b0;
                  r_state <= DRAIN;
               end else begin
                  r_col  <= r_col + c_COL_W'(1);
                  r_addr <= r_addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               // Wait out the read-data latency so the buffer holds the full row.
               if (r_drain == c_DRN_LAST) begin
                  r_row_valid <= 1'b1;
                  r_state     <= HOLD;
               end else begin
                  r_drain <= r_drain + 1'b1;
               end
            end
            HOLD: begin
               if (row_ack) begin
                  r_row_valid <= 1'b0;
                  r_row       <= r_row + c_ROW_W'(1);
                  r_col       <= '0;
                  r_addr      <= r_addr + ADDR_W'(1);
                  if (r_row == c_LAST_ROW) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_rd_en <= 1'b1;
                     r_state <= FETCH;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_d1 <= 1'b0;
      end else begin
         r_rd_d1 <= r_rd_en;
      end
   end

`ifdef WGT_RDATA_REG_EN
   logic               r_rd_d2;
   logic signed [7:0]  r_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_d2 <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_rd_d2 <= r_rd_d1;
         r_rdata <= r_rd_d1 ? wgt_rdata : 8'sd0;
      end
   end

   assign wgt_read  = r_rd_d2;
   assign wgt_input = r_rdata;
`else
   // Data is forced to zero outside the strobe so the port is quiet in reset.
   assign wgt_read  = r_rd_d1;
   assign wgt_input = r_rd_d1 ? wgt_rdata : 8'sd0;
`endif

   assign wgt_rd_en = r_rd_en;
   assign wgt_addr  = r_addr;
   assign row_valid = r_row_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wgt_loader.sv
`default_nettype none
// ============================================================================
// tb_wgt_loader : table-driven, scoreboard-checked bench for wgt_loader.
// Revision      : 1.0
// ============================================================================
module tb_wgt_loader;

`ifdef WGT_RDATA_REG_EN
   localparam int c_LAT = 2;
`else
   localparam int c_LAT = 1;
`endif

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [11:0]        base_addr;
   logic               wgt_rd_en;
   logic [11:0]        wgt_addr;
   logic signed [7:0]  wgt_rdata;
   logic signed [7:0]  wgt_input;
   logic               wgt_read;
   logic               row_valid;
   logic               row_ack;
   logic               busy;
   logic               done;

   int checks;
   int failures;
   int mem_mode;

   logic [11:0] exp_addr_q[$];
   logic [7:0]  exp_data_q[$];

   typedef struct {
      logic [11:0] base;
      int          mode;
      int          stall_row;
      int          stall_len;
      bit          start_noise;
      bit          ack_noise;
      logic [11:0] exp_last_addr;
      int          exp_reads;
   } vec_t;

   vec_t vecs[5];

   wgt_loader #(.KSIZE(5), .ADDR_W(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .wgt_rd_en (wgt_rd_en),
      .wgt_addr  (wgt_addr),
      .wgt_rdata (wgt_rdata),
      .wgt_input (wgt_input),
      .wgt_read  (wgt_read),
      .row_valid (row_valid),
      .row_ack   (row_ack),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mem_f(input logic [11:0] a, input int mode);
      if (mode == 1) return a[0] ? 8'h7F : 8'h80;
      return a[7:0];
   endfunction

   // One-cycle-latency SRAM model
   always @(posedge clk) begin
      if (wgt_rd_en) wgt_rdata <= mem_f(wgt_addr, mem_mode);
   end

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
      end
   endtask

   task automatic check_all_zero(input string name);
      check(wgt_rd_en == 1'b0, {name, "_rd_en"}, int'(wgt_rd_en), 0);
      check(wgt_addr == 12'h000, {name, "_addr"}, int'(wgt_addr), 0);
      check(wgt_input == 8'sd0, {name, "_input"}, int'(wgt_input), 0);
      check(wgt_read == 1'b0, {name, "_read"}, int'(wgt_read), 0);
      check(row_valid == 1'b0, {name, "_row_valid"}, int'(row_valid), 0);
      check(busy == 1'b0, {name, "_busy"}, int'(busy), 0);
      check(done == 1'b0, {name, "_done"}, int'(done), 0);
   endtask

   task automatic run_load(input vec_t v);
      int          t;
      int          reads;
      int          row;
      int          stall_left;
      int          rv_exp_t;
      bit          prev_rv;
      bit          acked;
      bit          fin;
      logic [11:0] a;
      logic [11:0] last_addr;
      logic [7:0]  ed;
      logic [7:0]  tap[5];

      exp_addr_q.delete();
      exp_data_q.delete();
      mem_mode = v.mode;
      for (int r = 0; r < 25; r++) begin
         a = v.base + 12'(r);
         exp_addr_q.push_back(a);
         exp_data_q.push_back(mem_f(a, v.mode));
      end
      for (int i = 0; i < 5; i++) tap[i] = 8'h00;

      @(negedge clk);
      base_addr = v.base;
      start     = 1'b1;
      @(posedge clk);
      t = 0; reads = 0; row = 0; prev_rv = 0; acked = 0; fin = 0;
      stall_left = v.stall_len;
      rv_exp_t   = 5 + c_LAT;
      last_addr  = 12'h000;

      while (!fin && t < 600) begin
         @(negedge clk);
         start   = 1'b0;
         row_ack = 1'b0;
         if (t == 0) begin
            check(wgt_rd_en == 1'b1, "first_rd_en", int'(wgt_rd_en), 1);
            check(busy == 1'b1, "busy_rise", int'(busy), 1);
         end
         if (wgt_rd_en) begin
            reads++;
            if (exp_addr_q.size() == 0) begin
               check(1'b0, "extra_read", reads, v.exp_reads);
            end else begin
               a = exp_addr_q.pop_front();
               check(wgt_addr == a, "addr", int'(wgt_addr), int'(a));
               last_addr = wgt_addr;
            end
         end
         if (wgt_read) begin
            if (exp_data_q.size() == 0) begin
               check(1'b0, "extra_wgt_read", 1, 0);
            end else begin
               ed = exp_data_q.pop_front();
               check(wgt_input == ed, "wgt_input", int'(wgt_input), int'(ed));
               if (v.mode == 1)
                  check(int'(wgt_input) == ((ed == 8'h80) ? -128 : 127), "signed_value",
                        int'(wgt_input), (ed == 8'h80) ? -128 : 127);
            end
            for (int i = 4; i > 0; i--) tap[i] = tap[i-1];
            tap[0] = wgt_input;
         end
         if (acked) begin
            acked = 0;
            check(row_valid == 1'b0, "row_valid_drop", int'(row_valid), 0);
            if (row == 5) begin
               check(done == 1'b1, "done_pulse", int'(done), 1);
               check(busy == 1'b0, "busy_in_done", int'(busy), 0);
               start = 1'b1;
               fin   = 1;
            end else begin
               check(wgt_rd_en == 1'b1, "resume_rd_en", int'(wgt_rd_en), 1);
            end
         end else begin
            if (done) check(1'b0, "early_done", t, 0);
            if (prev_rv && !row_valid) check(1'b0, "row_valid_hold", 0, 1);
            if (row_valid && !prev_rv) begin
               check(t == rv_exp_t, "row_valid_rise_cycle", t, rv_exp_t);
               for (int c = 0; c < 5; c++) begin
                  ed = mem_f(v.base + 12'(row * 5 + c), v.mode);
                  check(tap[4-c] == ed, "buffer_tap", int'(tap[4-c]), int'(ed));
               end
            end
         end
         if (row_valid && (wgt_rd_en || wgt_read))
            check(1'b0, "strobe_in_hold", int'({wgt_rd_en, wgt_read}), 0);
         if (row_valid && !fin) begin
            if (row == v.stall_row && stall_left > 0) begin
               stall_left--;
            end else begin
               row_ack  = 1'b1;
               acked    = 1;
               row++;
               rv_exp_t = t + 1 + 5 + c_LAT;
            end
         end
         if (!fin) begin
            if (v.ack_noise && wgt_rd_en) row_ack = 1'b1;
            if (v.start_noise && (t % 3 == 1)) start = 1'b1;
         end
         prev_rv = row_valid;
         t++;
      end
      check(fin, "load_timeout", t, 600);
      check(reads == v.exp_reads, "read_count", reads, v.exp_reads);
      check(last_addr == v.exp_last_addr, "last_addr", int'(last_addr), int'(v.exp_last_addr));
      check(exp_data_q.size() == 0, "data_left", exp_data_q.size(), 0);
      @(negedge clk);
      start   = 1'b0;
      row_ack = 1'b0;
      check(wgt_rd_en == 1'b0, "start_in_done_ignored", int'(wgt_rd_en), 0);
      check(busy == 1'b0, "idle_after_done", int'(busy), 0);
   endtask

   initial begin
      int reads;
      int budget;

      checks = 0; failures = 0; mem_mode = 0;
      rst_n = 1'b0; start = 1'b0; base_addr = 12'h000; row_ack = 1'b0;
      wgt_rdata = 8'sd0;

      //            base     mode stall_row len  s_noise a_noise last     reads
      vecs[0] = '{12'h010, 0, -1,  0, 1'b0, 1'b0, 12'h028, 25};
      vecs[1] = '{12'h010, 0,  2, 20, 1'b0, 1'b0, 12'h028, 25};
      vecs[2] = '{12'h3A0, 1, -1,  0, 1'b0, 1'b0, 12'h3B8, 25};
      vecs[3] = '{12'hFF0, 0, -1,  0, 1'b0, 1'b0, 12'h008, 25};
      vecs[4] = '{12'h055, 0,  1,  3, 1'b1, 1'b1, 12'h06D, 25};

      #1;
      check_all_zero("reset_state");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check(busy == 1'b0, "idle_busy", int'(busy), 0);

      for (int k = 0; k < 5; k++) run_load(vecs[k]);

      // Reset in the middle of fetching row 3
      mem_mode = 0;
      @(negedge clk);
      base_addr = 12'h200;
      start     = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      row_ack = 1'b1;
      reads   = (wgt_rd_en) ? 1 : 0;
      budget  = 0;
      while (reads < 17 && budget < 300) begin
         @(negedge clk);
         if (wgt_rd_en) reads++;
         budget++;
      end
      check(reads == 17 && wgt_rd_en == 1'b1, "reach_row3_fetch", reads, 17);
      #2;
      rst_n   = 1'b0;
      start   = 1'b1;
      row_ack = 1'b1;
      #1;
      check_all_zero("async_reset");
      repeat (3) @(negedge clk);
      check_all_zero("held_reset");
      rst_n   = 1'b1;
      start   = 1'b0;
      row_ack = 1'b0;
      repeat (2) @(negedge clk);
      check(busy == 1'b0 && wgt_rd_en == 1'b0, "idle_after_reset", int'({busy, wgt_rd_en}), 0);
      run_load('{12'h100, 0, -1, 0, 1'b0, 1'b0, 12'h118, 25});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
